// File: rtl/lbuffer_pkg.sv
// Shared load-buffer types: widths, load opcodes,
// memory access sizes and the queued entry layout.
package lbuffer_pkg;

    localparam int AddressWidth  = 32;
    localparam int ROBWidth      = 4;
    localparam int InstTypeWidth = 6;

    typedef logic [InstTypeWidth-1:0] op_t;

    localparam op_t LB  = 6'd10;
    localparam op_t LH  = 6'd11;
    localparam op_t LW  = 6'd12;
    localparam op_t LBU = 6'd13;
    localparam op_t LHU = 6'd14;

    localparam logic [1:0] MemByte = 2'd0;
    localparam logic [1:0] MemHalf = 2'd1;
    localparam logic [1:0] MemWord = 2'd2;

    typedef struct packed {
        logic [AddressWidth-1:0] addr;
        logic [ROBWidth-1:0]     dest;
        op_t                     op;
    } lb_entry_t;

    function automatic logic [1:0] mem_size(op_t op);
        logic [1:0] sz;
        sz = MemWord;
        unique case (1'b1)
            (op == LB) || (op == LBU): sz = MemByte;
            (op == LH) || (op == LHU): sz = MemHalf;
            default:                   sz = MemWord;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lbuffer_if.sv
// Bundle of address-unit, ROB, memory and CDB signals
// around the load buffer; master is the buffer side.
interface lbuffer_if;
    import lbuffer_pkg::*;

    logic                     addrunit_lbuffer_en_in;
    logic [AddressWidth-1:0]  addrunit_lbuffer_a_in;
    logic [ROBWidth-1:0]      addrunit_lbuffer_dest_in;
    op_t                      addrunit_lbuffer_opcode_in;
    logic                     lbuffer_full_out;
    logic                     rob_lbuffer_store_busy_in;
    logic                     rob_lbuffer_rst_in;
    logic                     lbuffer_mem_req_out;
    logic [AddressWidth-1:0]  lbuffer_mem_addr_out;
    logic [1:0]               lbuffer_mem_size_out;
    logic                     mem_lbuffer_done_in;
    logic [31:0]              mem_lbuffer_data_in;
    logic                     lbuffer_cdb_en_out;
    logic [ROBWidth-1:0]      lbuffer_cdb_dest_out;
    logic [31:0]              lbuffer_cdb_value_out;

    modport master (
        input  addrunit_lbuffer_en_in, addrunit_lbuffer_a_in,
        input  addrunit_lbuffer_dest_in, addrunit_lbuffer_opcode_in,
        input  rob_lbuffer_store_busy_in, rob_lbuffer_rst_in,
        input  mem_lbuffer_done_in, mem_lbuffer_data_in,
        output lbuffer_full_out,
        output lbuffer_mem_req_out, lbuffer_mem_addr_out,
        output lbuffer_mem_size_out,
        output lbuffer_cdb_en_out, lbuffer_cdb_dest_out,
        output lbuffer_cdb_value_out
    );

    modport slave (
        output addrunit_lbuffer_en_in, addrunit_lbuffer_a_in,
        output addrunit_lbuffer_dest_in, addrunit_lbuffer_opcode_in,
        output rob_lbuffer_store_busy_in, rob_lbuffer_rst_in,
        output mem_lbuffer_done_in, mem_lbuffer_data_in,
        input  lbuffer_full_out,
        input  lbuffer_mem_req_out, lbuffer_mem_addr_out,
        input  lbuffer_mem_size_out,
        input  lbuffer_cdb_en_out, lbuffer_cdb_dest_out,
        input  lbuffer_cdb_value_out
    );

endinterface

// File: rtl/lbuffer_extend.sv
// Opcode-driven sign/zero extension of right-aligned
// load data; shared with future store forwarding.
module lbuffer_extend
    import lbuffer_pkg::*;
(
    input  op_t         op,
    input  logic [31:0] data,
    output logic [31:0] value
);

    always_comb begin
        value = data;
        unique case (1'b1)
            op == LB:  value = {{24{data[7]}}, data[7:0]};
            op == LBU: value = {24'd0, data[7:0]};
            op == LH:  value = {{16{data[15]}}, data[15:0]};
            op == LHU: value = {16'd0, data[15:0]};
            default:   value = data;
        endcase
    end

endmodule

// File: rtl/lbuffer.sv
// In-order load buffer: queues resolved loads, issues
// one at a time to memory, broadcasts results on CDB.
module lbuffer
    import lbuffer_pkg::*;
#(
    parameter int LB_DEPTH = 8,
    parameter int LB_PTR_W = $clog2(LB_DEPTH)
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    lbuffer_if.master bus
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [LB_PTR_W:0] FULL_CNT = LB_DEPTH[LB_PTR_W:0];
    localparam logic [LB_PTR_W:0] HIGH_CNT = FULL_CNT - 1'b1;

    state_t              state, state_nx;
    lb_entry_t           ent_q [LB_DEPTH];
    lb_entry_t           head_ent;
    logic [LB_PTR_W-1:0] head, tail;
    logic [LB_PTR_W:0]   count;
    logic                flush, enq, deq;
    logic                cdb_en;
    logic [ROBWidth-1:0] cdb_dest;
    logic [31:0]         cdb_value, ext_value;

    assign head_ent = ent_q[head];
    assign flush    = bus.rob_lbuffer_rst_in;
    // Overflowing enqueues are dropped rather than corrupting the head.
    assign enq = rdy_in && !flush && bus.addrunit_lbuffer_en_in
              && (count != FULL_CNT);
    assign deq = rdy_in && !flush && (state == WAIT)
              && bus.mem_lbuffer_done_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= flush ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (count != '0 && !bus.rob_lbuffer_store_busy_in)
                      state_nx = WAIT;
            WAIT: if (bus.mem_lbuffer_done_in)
                      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.lbuffer_mem_req_out  = 1'b0;
        bus.lbuffer_mem_addr_out = '0;
        bus.lbuffer_mem_size_out = MemByte;
        if (state == WAIT) begin
            bus.lbuffer_mem_req_out  = 1'b1;
            bus.lbuffer_mem_addr_out = head_ent.addr;
            bus.lbuffer_mem_size_out = mem_size(head_ent.op);
        end
    end

    always_ff @(posedge clk_in) begin
        if (enq) begin
            ent_q[tail] <= '{addr: bus.addrunit_lbuffer_a_in,
                             dest: bus.addrunit_lbuffer_dest_in,
                             op:   bus.addrunit_lbuffer_opcode_in};
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            cdb_en    <= 1'b0;
            cdb_dest  <= '0;
            cdb_value <= '0;
        end else if (rdy_in) begin
            cdb_en <= 1'b0;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq)
                    tail <= tail + 1'b1;
                if (deq) begin
                    head      <= head + 1'b1;
                    cdb_en    <= 1'b1;
                    cdb_dest  <= head_ent.dest;
                    cdb_value <= ext_value;
                end
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    lbuffer_extend u_extend (
        .op    (head_ent.op),
        .data  (bus.mem_lbuffer_data_in),
        .value (ext_value)
    );

    assign bus.lbuffer_full_out      = (count >= HIGH_CNT);
    assign bus.lbuffer_cdb_en_out    = cdb_en;
    assign bus.lbuffer_cdb_dest_out  = cdb_dest;
    assign bus.lbuffer_cdb_value_out = cdb_value;

endmodule

// File: tb/tb_lbuffer.sv
// Directed bench for lbuffer: extension, ordering, full flag,
// store hazard, flush, enqueue/complete overlap, reset, stall.
module tb_lbuffer;
    import lbuffer_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;
    int   n_chk = 0;
    int   n_err = 0;
    int   tb_cnt = 0;

    lbuffer_if bus ();

    lbuffer #(.LB_DEPTH(8)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [3:0] d,
                       input op_t op);
        assert (tb_cnt < 8) else $error("enqueue into full buffer");
        bus.addrunit_lbuffer_en_in     = 1'b1;
        bus.addrunit_lbuffer_a_in      = a;
        bus.addrunit_lbuffer_dest_in   = d;
        bus.addrunit_lbuffer_opcode_in = op;
        tb_cnt++;
        tick();
        bus.addrunit_lbuffer_en_in = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!bus.lbuffer_mem_req_out && n < budget) begin
            tick();
            n++;
        end
        chk("req_wait", bus.lbuffer_mem_req_out, 1);
    endtask

    task automatic finish_load(input logic [3:0] d,
                               input logic [31:0] data,
                               input logic [31:0] expv);
        bus.mem_lbuffer_done_in = 1'b1;
        bus.mem_lbuffer_data_in = data;
        tick();
        bus.mem_lbuffer_done_in = 1'b0;
        tb_cnt--;
        chk("cdb_en", bus.lbuffer_cdb_en_out, 1);
        chk("cdb_dest", bus.lbuffer_cdb_dest_out, d);
        chk("cdb_value", bus.lbuffer_cdb_value_out, expv);
        chk("req_drop", bus.lbuffer_mem_req_out, 0);
        tick();
        chk("cdb_pulse", bus.lbuffer_cdb_en_out, 0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] d,
                           input op_t op, input logic [31:0] data,
                           input logic [31:0] expv,
                           input logic [1:0] sz);
        enq(a, d, op);
        chk("issue_lat", bus.lbuffer_mem_req_out, 0);
        tick();
        chk("req", bus.lbuffer_mem_req_out, 1);
        chk("addr", bus.lbuffer_mem_addr_out, a);
        chk("size", bus.lbuffer_mem_size_out, sz);
        finish_load(d, data, expv);
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        bus.addrunit_lbuffer_en_in     = 1'b0;
        bus.addrunit_lbuffer_a_in      = '0;
        bus.addrunit_lbuffer_dest_in   = '0;
        bus.addrunit_lbuffer_opcode_in = '0;
        bus.rob_lbuffer_store_busy_in  = 1'b0;
        bus.rob_lbuffer_rst_in         = 1'b0;
        bus.mem_lbuffer_done_in        = 1'b0;
        bus.mem_lbuffer_data_in        = '0;
        tick();
        tick();
        chk("rst_req", bus.lbuffer_mem_req_out, 0);
        chk("rst_addr", bus.lbuffer_mem_addr_out, 0);
        chk("rst_size", bus.lbuffer_mem_size_out, 0);
        chk("rst_full", bus.lbuffer_full_out, 0);
        chk("rst_cdb_en", bus.lbuffer_cdb_en_out, 0);
        chk("rst_cdb_dest", bus.lbuffer_cdb_dest_out, 0);
        chk("rst_cdb_val", bus.lbuffer_cdb_value_out, 0);
        rst_n = 1'b1;
        tick();

        // extension per opcode
        do_load(32'h100, 4'd3, LB,  32'h0000_00F0, 32'hFFFF_FFF0, 2'd0);
        do_load(32'h104, 4'd4, LBU, 32'h0000_00F0, 32'h0000_00F0, 2'd0);
        do_load(32'h108, 4'd5, LH,  32'h1234_8001, 32'hFFFF_8001, 2'd1);
        do_load(32'h10C, 4'd6, LHU, 32'h1234_8001, 32'h0000_8001, 2'd1);
        do_load(32'h110, 4'd7, LW,  32'h8765_4321, 32'h8765_4321, 2'd2);
        do_load(32'h114, 4'd8, LB,  32'hABCD_EF7F, 32'h0000_007F, 2'd0);

        // order and full flag, pointers wrap
        for (int i = 1; i <= 7; i++) begin
            enq(32'h200 + 32'(4 * i), 4'(i), LW);
            chk("full_fill", bus.lbuffer_full_out, (i >= 7) ? 1 : 0);
        end
        for (int i = 1; i <= 7; i++) begin
            wait_req(6);
            chk("ord_addr", bus.lbuffer_mem_addr_out,
                32'h200 + 32'(4 * i));
            finish_load(4'(i), 32'(i * 17), 32'(i * 17));
            if (i == 1)
                chk("full_drop", bus.lbuffer_full_out, 0);
        end
        for (int i = 8; i <= 12; i++)
            enq(32'h280 + 32'(4 * i), 4'(i), LBU);
        for (int i = 8; i <= 12; i++) begin
            wait_req(6);
            chk("wrap_addr", bus.lbuffer_mem_addr_out,
                32'h280 + 32'(4 * i));
            finish_load(4'(i), 32'h0000_FF80 + 32'(i),
                        32'h0000_0080 + 32'(i));
        end
        tick();
        chk("drain_req", bus.lbuffer_mem_req_out, 0);

        // store hazard
        bus.rob_lbuffer_store_busy_in = 1'b1;
        enq(32'h300, 4'd1, LW);
        enq(32'h304, 4'd2, LW);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hazard_hold", bus.lbuffer_mem_req_out, 0);
        end
        bus.rob_lbuffer_store_busy_in = 1'b0;
        tick();
        chk("hazard_req", bus.lbuffer_mem_req_out, 1);
        chk("hazard_addr", bus.lbuffer_mem_addr_out, 32'h300);
        bus.rob_lbuffer_store_busy_in = 1'b1;
        finish_load(4'd1, 32'h11, 32'h11);
        tick();
        chk("hazard_idle", bus.lbuffer_mem_req_out, 0);
        bus.rob_lbuffer_store_busy_in = 1'b0;
        wait_req(4);
        chk("hazard_addr2", bus.lbuffer_mem_addr_out, 32'h304);
        finish_load(4'd2, 32'h22, 32'h22);

        // flush in the same cycle as done
        enq(32'h400, 4'd5, LH);
        tick();
        chk("fl_req", bus.lbuffer_mem_req_out, 1);
        chk("fl_size", bus.lbuffer_mem_size_out, 1);
        bus.mem_lbuffer_done_in = 1'b1;
        bus.mem_lbuffer_data_in = 32'h0000_8000;
        bus.rob_lbuffer_rst_in  = 1'b1;
        tick();
        bus.mem_lbuffer_done_in = 1'b0;
        bus.rob_lbuffer_rst_in  = 1'b0;
        tb_cnt = 0;
        chk("fl_cdb", bus.lbuffer_cdb_en_out, 0);
        chk("fl_req0", bus.lbuffer_mem_req_out, 0);
        tick();
        chk("fl_empty", bus.lbuffer_mem_req_out, 0);
        chk("fl_full", bus.lbuffer_full_out, 0);

        // enqueue in the same cycle as completion
        enq(32'h500, 4'd6, LW);
        tick();
        chk("ov_req", bus.lbuffer_mem_req_out, 1);
        bus.mem_lbuffer_done_in        = 1'b1;
        bus.mem_lbuffer_data_in        = 32'h600D_0006;
        bus.addrunit_lbuffer_en_in     = 1'b1;
        bus.addrunit_lbuffer_a_in      = 32'h504;
        bus.addrunit_lbuffer_dest_in   = 4'd7;
        bus.addrunit_lbuffer_opcode_in = LW;
        tick();
        bus.mem_lbuffer_done_in    = 1'b0;
        bus.addrunit_lbuffer_en_in = 1'b0;
        chk("ov_cdb_en", bus.lbuffer_cdb_en_out, 1);
        chk("ov_cdb_dest", bus.lbuffer_cdb_dest_out, 6);
        tick();
        chk("ov_req2", bus.lbuffer_mem_req_out, 1);
        chk("ov_addr2", bus.lbuffer_mem_addr_out, 32'h504);
        finish_load(4'd7, 32'h600D_0007, 32'h600D_0007);
        tick();
        chk("ov_empty", bus.lbuffer_mem_req_out, 0);

        // reset mid-WAIT
        enq(32'h600, 4'd2, LB);
        tick();
        chk("rw_req", bus.lbuffer_mem_req_out, 1);
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        tb_cnt = 0;
        chk("rw_req0", bus.lbuffer_mem_req_out, 0);
        chk("rw_addr0", bus.lbuffer_mem_addr_out, 0);
        chk("rw_cdb0", bus.lbuffer_cdb_en_out, 0);
        chk("rw_val0", bus.lbuffer_cdb_value_out, 0);
        tick();
        chk("rw_empty", bus.lbuffer_mem_req_out, 0);

        // rdy low during WAIT, done ignored
        enq(32'h700, 4'd3, LH);
        tick();
        chk("st_req", bus.lbuffer_mem_req_out, 1);
        rdy = 1'b0;
        bus.mem_lbuffer_done_in = 1'b1;
        bus.mem_lbuffer_data_in = 32'h0000_7FFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_hold_req", bus.lbuffer_mem_req_out, 1);
            chk("st_hold_addr", bus.lbuffer_mem_addr_out, 32'h700);
            chk("st_hold_cdb", bus.lbuffer_cdb_en_out, 0);
        end
        bus.mem_lbuffer_done_in = 1'b0;
        rdy = 1'b1;
        tick();
        chk("st_req_after", bus.lbuffer_mem_req_out, 1);
        finish_load(4'd3, 32'h0000_7FFF, 32'h0000_7FFF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lbuffer.md
# lbuffer

Load buffer sitting directly downstream of the address unit in the Tomasulo core. It queues address-resolved loads in program order, issues them one at a time to the memory controller, sign- or zero-extends the returned data, and broadcasts the result on the common data bus (CDB) tagged with the load's ROB entry. The reorder buffer can flush the whole buffer on misprediction.

## Interface
Parameters:
- `LB_DEPTH`, 8: number of entries; must be a power of two and at least 2.
- `LB_PTR_W`, $clog2(LB_DEPTH): pointer width.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset, synchronous, active-low.
- `rdy_in` in 1: global enable. When low, all state holds.
- `addrunit_lbuffer_en_in` in 1: a load is presented this cycle.
- `addrunit_lbuffer_a_in` in `AddressWidth: effective address.
- `addrunit_lbuffer_dest_in` in `ROBWidth: ROB tag of the load.
- `addrunit_lbuffer_opcode_in` in `InstTypeWidth: one of `LB`, `LH`, `LW`, `LBU`, `LHU`.
- `lbuffer_full_out` out 1: stall request to issue logic.
- `rob_lbuffer_store_busy_in` in 1: an uncommitted store older than the head load exists.
- `rob_lbuffer_rst_in` in 1: flush.
- `lbuffer_mem_req_out` out 1: memory read request, held until done.
- `lbuffer_mem_addr_out` out `AddressWidth: request address.
- `lbuffer_mem_size_out` out 2: access size. 0 = byte, 1 = half, 2 = word.
- `mem_lbuffer_done_in` in 1: read complete, one-cycle pulse.
- `mem_lbuffer_data_in` in 32: raw data, right-aligned.
- `lbuffer_cdb_en_out` out 1: result valid.
- `lbuffer_cdb_dest_out` out `ROBWidth: ROB tag of the result.
- `lbuffer_cdb_value_out` out 32: extended load value.

## Operation
- **Storage.** Circular FIFO. Each entry holds `{addr, dest, opcode}`. `head` and `tail` are `LB_PTR_W` bits and wrap modulo `LB_DEPTH`. A `count` of width `LB_PTR_W+1` tracks occupancy.
- **Enqueue.** When `addrunit_lbuffer_en_in` and `rdy_in` are high, write the entry at `tail` and increment `tail`. Enqueue while `count == LB_DEPTH` is a protocol violation: the bench asserts on it, and RTL drops the load.
- **Full flag.** `lbuffer_full_out` = (`count >= LB_DEPTH-1`). The one-slot margin covers the load already in flight through the RS and address unit.
- **FSM.** Two states, IDLE and WAIT.
  - IDLE → WAIT when `count != 0` and `!rob_lbuffer_store_busy_in`.
  - WAIT holds until `mem_lbuffer_done_in`, then returns to IDLE and dequeues the head (`head++`).
  - `lbuffer_mem_req_out` = (state == WAIT).
  - Address and size are driven from the head entry.
  - Size mapping: `LB`/`LBU` → 0, `LH`/`LHU` → 1, `LW` → 2.
- **Result.** On done, register:
  - `cdb_en` = 1;
  - `cdb_dest` = head dest;
  - `cdb_value` by opcode:
    - `LB`: sign-extend `data[7:0]`;
    - `LBU`: zero-extend `data[7:0]`;
    - `LH`: sign-extend `data[15:0]`;
    - `LHU`: zero-extend `data[15:0]`;
    - `LW`: `data` unchanged.
  - `cdb_en` is high for exactly one cycle.
- **Flush.** When `rob_lbuffer_rst_in` is high with `rdy_in`:
  - `head`, `tail` and `count` go to 0; FSM goes to IDLE.
  - `cdb_en` goes to 0 next cycle.
  - A `done` arriving in the same cycle is discarded, with no broadcast.
  - Dropping `lbuffer_mem_req_out` is the abort indication to the memory controller.
- **Priorities.** Reset > flush > normal operation.
  - Simultaneous enqueue and dequeue leaves `count` unchanged.
  - Flush and enqueue in the same cycle: flush wins and the load is dropped.

## Timing
- **Reset values.** All outputs are 0. `lbuffer_full_out` is 0 because `count` = 0. FSM is in IDLE.
- **Enqueue.** An enqueue at edge N makes the entry visible at the head in cycle N+1.
- **Issue.** With `store_busy` low, WAIT (and `req`) is entered at edge N+1. `req` is high from cycle N+2.
- **Result.** `done` in cycle M gives `cdb_en` high in cycle M+1. The next request can assert in cycle M+2 at the earliest.
- **Store hazard.** `store_busy` is sampled only in IDLE. Once in WAIT, the request is never withdrawn except by flush.
- **Stall.** With `rdy_in` low, pointers, FSM and registered outputs hold. A `done` during `rdy_in` low is not accepted; the memory controller is gated by the same `rdy_in`.

## Structure
- The shared `constant.vh` gains or keeps:
  - the `LB`…`LHU` opcodes;
  - `AddressWidth`, `ROBWidth`, `InstTypeWidth`;
  - the size encodings `MemByte`, `MemHalf`, `MemWord`.
- FSM state encodings are local to the block.
- One sub-module, `lbuffer_extend`: combinational opcode-driven extension, (opcode, data) → value. It is reusable by a future store-to-load forwarding path.

## Test plan
- **Sign/zero extension.** Enqueue an `LB` at `0x100`; mem returns `0x000000F0` → CDB value `0xFFFFFFF0`, dest matches, `cdb_en` one cycle. Repeat with `LBU` → `0x000000F0`.
- **Order and full flag.** Enqueue 7 loads with `done` held off → `lbuffer_full_out` rises when `count` = 7. Then complete all → broadcasts appear in enqueue order with tags 1..7; `head` and `tail` wrap correctly on a second batch of 5.
- **Store hazard.** Hold `store_busy` = 1 with 2 entries queued → `req` stays 0. Release it → `req` rises 1 cycle later with the head address.
- **Flush mid-access.** Flush in the same cycle as `done` during an `LH` → no CDB pulse, `count` = 0, `req` = 0 next cycle.
- **Simultaneous enqueue and completion.** Enqueue in the same cycle as a `done` → `count` unchanged, the new entry is issued next.
- **Reset and `rdy_in`.** Reset mid-WAIT → all outputs 0 the next cycle. With `rdy_in` = 0 for 3 cycles during WAIT → state, `req` and address unchanged.
